// File: rtl/store_pkg.sv
// Purpose: shared store-path definitions: store-size mode codes and the byte-lane mask helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: MODE_SB/SH/SW/SD codes; lane_mask(mode, xlen) returns the right-justified byte mask of a store.
package store_pkg;

    localparam logic [1:0] MODE_SB = 2'b00;
    localparam logic [1:0] MODE_SH = 2'b01;
    localparam logic [1:0] MODE_SW = 2'b10;
    localparam logic [1:0] MODE_SD = 2'b11;

    // Byte mask of the store size, bit i = byte i of the right-justified data.
    // A doubleword on a 32-bit core degrades to a word.
    function automatic logic [7:0] lane_mask(input logic [1:0] mode, input int xlen);
        logic [7:0] m;
        case (mode)
            MODE_SB: m = 8'h01;
            MODE_SH: m = 8'h03;
            MODE_SW: m = 8'h0F;
            default: m = (xlen == 64) ? 8'hFF : 8'h0F;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_buffer_unit_if.sv
// Purpose: store request channel (st_*) plus data-memory write channel (mem_*) of the store buffer.
// Latency: n/a (wires only).
// Backpressure: st_* uses st_valid/st_ready; mem_* uses mem_valid/mem_ready.
// Modports: master = execute stage / memory side environment, slave = store_buffer_unit.
interface store_buffer_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_mode;
    logic [ADDR_W-1:0] st_addr;
    logic [XLEN-1:0]   st_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NB-1:0]     mem_wstrb;

    modport master (
        output st_valid, st_mode, st_addr, st_data, mem_ready,
        input  st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  st_valid, st_mode, st_addr, st_data, mem_ready,
        output st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_lane_align.sv
// Purpose: places right-justified store data onto byte lanes and builds strobes for up to two bus beats.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: mode/off/data in; beat0/beat1 data+strobes out; split=1 when the store spills into the next word.
module store_lane_align
    import store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                   mode,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [XLEN-1:0]              data,
    output logic [XLEN-1:0]              beat0_dat,
    output logic [XLEN-1:0]              beat1_dat,
    output logic [XLEN/8-1:0]            beat0_strb,
    output logic [XLEN/8-1:0]            beat1_strb,
    output logic                         split
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]     lmask;
    logic [XLEN-1:0]   dmask;
    logic [2*XLEN-1:0] wide_d;
    logic [2*NB-1:0]   wide_s;

    always_comb begin
        lmask = NB'(lane_mask(mode, XLEN));
        dmask = '0;
        for (int i = 0; i < NB; i++) begin
            dmask[8*i +: 8] = {8{lmask[i]}};
        end
        // Shift across a double-width window so bytes past the word end land in beat1.
        wide_d     = {{XLEN{1'b0}}, data & dmask} << {off, 3'b000};
        wide_s     = {{NB{1'b0}}, lmask} << off;
        beat0_dat  = wide_d[XLEN-1:0];
        beat1_dat  = wide_d[2*XLEN-1:XLEN];
        beat0_strb = wide_s[NB-1:0];
        beat1_strb = wide_s[2*NB-1:NB];
        split      = |wide_s[2*NB-1:NB];
    end
endmodule

// File: rtl/store_buffer_unit.sv
// Purpose: store path; aligns stores, splits word-crossing stores into two beats, queues beats to data memory.
// Latency: accepted store appears on mem_* the cycle after acceptance when the queue was empty.
// Backpressure: st_ready only while two free slots remain (count <= DEPTH-2); mem_* held while !mem_ready.
// Ports: clk, rst_n (sync, active low), bus (slave modport: st_* in, mem_* out), buf_empty, buf_count.
module store_buffer_unit
    import store_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    store_buffer_unit_if.slave      bus,
    output logic                    buf_empty,
    output logic [$clog2(DEPTH):0]  buf_count
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]   dat_q  [DEPTH];
    logic [NB-1:0]     strb_q [DEPTH];

    // Last popped beat; mem_* show it while the queue is empty.
    logic [ADDR_W-1:0] last_addr;
    logic [XLEN-1:0]   last_dat;
    logic [NB-1:0]     last_strb;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_p1;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] base;
    logic [XLEN-1:0]   b0_dat, b1_dat;
    logic [NB-1:0]     b0_strb, b1_strb;
    logic              split, push, pop, head_vld;

    store_lane_align #(.XLEN(XLEN)) u_align (
        .mode       (bus.st_mode),
        .off        (bus.st_addr[OFF_W-1:0]),
        .data       (bus.st_data),
        .beat0_dat  (b0_dat),
        .beat1_dat  (b1_dat),
        .beat0_strb (b0_strb),
        .beat1_strb (b1_strb),
        .split      (split)
    );

    assign base      = {bus.st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
    assign head_vld  = (count != '0);

    // Two slots are always kept free so a split store never has to be refused mid-way.
    assign bus.st_ready = (count <= CNT_W'(DEPTH - 2));
    assign push         = bus.st_valid & bus.st_ready;
    assign pop          = head_vld & bus.mem_ready;

    assign bus.mem_valid = head_vld;
    assign bus.mem_addr  = head_vld ? addr_q[rd_ptr] : last_addr;
    assign bus.mem_wdata = head_vld ? dat_q[rd_ptr]  : last_dat;
    assign bus.mem_wstrb = head_vld ? strb_q[rd_ptr] : last_strb;
    assign buf_empty     = ~head_vld;
    assign buf_count     = count;

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= base;
            dat_q[wr_ptr]  <= b0_dat;
            strb_q[wr_ptr] <= b0_strb;
            if (split) begin
                addr_q[wr_ptr_p1] <= base + ADDR_W'(NB);
                dat_q[wr_ptr_p1]  <= b1_dat;
                strb_q[wr_ptr_p1] <= b1_strb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_addr <= '0;
            last_dat  <= '0;
            last_strb <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (split ? PTR_W'(2) : PTR_W'(1));
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_addr <= addr_q[rd_ptr];
                last_dat  <= dat_q[rd_ptr];
                last_strb <= strb_q[rd_ptr];
            end
            count <= count + CNT_W'(push) + CNT_W'(push & split) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_store_buffer_unit.sv
// Purpose: self-checking bench for store_buffer_unit (XLEN=32, ADDR_W=32, DEPTH=4).
// Latency: n/a.
// Backpressure: exercised through mem_ready stalls and st_ready drops.
module tb_store_buffer_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  strb;
    } beat_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
        int          nb;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic [31:0] a1, d1;
        logic [3:0]  s1;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       buf_empty;
    logic [2:0] buf_count;

    store_buffer_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();

    store_buffer_unit #(.XLEN(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .buf_empty (buf_empty),
        .buf_count (buf_count)
    );

    int    chk_cnt    = 0;
    int    pass_cnt   = 0;
    int    beats_exp  = 0;
    int    beats_seen = 0;
    beat_t sb_q[$];
    vec_t  vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        beat_t b;
        b.addr = a; b.dat = d; b.strb = s;
        sb_q.push_back(b);
        beats_exp++;
    endtask

    // Byte-by-byte reference: byte k of the store goes to lane off+k of a two-word window.
    task automatic push_model(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] data);
        int          nbytes;
        int          lane;
        logic [31:0] d0, d1;
        logic [3:0]  s0, s1;
        logic [31:0] base;
        nbytes = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
        d0 = '0; d1 = '0; s0 = '0; s1 = '0;
        for (int k = 0; k < nbytes; k++) begin
            lane = int'(addr[1:0]) + k;
            if (lane < 4) begin
                d0[8*lane +: 8] = data[8*k +: 8];
                s0[lane] = 1'b1;
            end else begin
                d1[8*(lane-4) +: 8] = data[8*k +: 8];
                s1[lane-4] = 1'b1;
            end
        end
        base = {addr[31:2], 2'b00};
        push_beat(base, d0, s0);
        if (s1 != 4'b0) push_beat(base + 32'd4, d1, s1);
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb_q.size() == 0 && buf_empty) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // Scoreboard consumer: every accepted beat is compared in order.
    always @(negedge clk) begin
        if (rst_n && bus.mem_valid && bus.mem_ready) begin
            beats_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check("beat_addr",  64'(bus.mem_addr),  64'(e.addr));
                check("beat_wdata", 64'(bus.mem_wdata), 64'(e.dat));
                check("beat_wstrb", 64'(bus.mem_wstrb), 64'(e.strb));
            end
        end
    end

    initial begin
        logic [1:0]  rmode;
        logic [31:0] raddr, rdata;
        int          accepted;

        vecs[0] = '{2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0};
        vecs[1] = '{2'd0, 32'h0000_0203, 32'h0000_00A5, 1, 32'h200, 32'hA500_0000, 4'b1000, 32'h0, 32'h0, 4'b0};
        vecs[2] = '{2'd2, 32'h0000_0302, 32'h1122_3344, 2, 32'h300, 32'h3344_0000, 4'b1100, 32'h304, 32'h0000_1122, 4'b0011};
        vecs[3] = '{2'd1, 32'h0000_0003, 32'hFFFF_BEEF, 2, 32'h0, 32'hEF00_0000, 4'b1000, 32'h4, 32'h0000_00BE, 4'b0001};
        vecs[4] = '{2'd0, 32'h0000_0040, 32'hFFFF_FF5A, 1, 32'h40, 32'h0000_005A, 4'b0001, 32'h0, 32'h0, 4'b0};
        vecs[5] = '{2'd3, 32'h0000_0401, 32'hAABB_CCDD, 2, 32'h400, 32'hBBCC_DD00, 4'b1110, 32'h404, 32'h0000_00AA, 4'b0001};
        vecs[6] = '{2'd2, 32'hFFFF_FFFE, 32'h1234_5678, 2, 32'hFFFF_FFFC, 32'h5678_0000, 4'b1100, 32'h0, 32'h0000_1234, 4'b0011};

        rst_n = 1'b0;
        bus.st_valid = 1'b0; bus.st_mode = 2'd0; bus.st_addr = '0; bus.st_data = '0;
        bus.mem_ready = 1'b0;
        tick(); tick();
        check("rst_empty",     64'(buf_empty),     64'd1);
        check("rst_count",     64'(buf_count),     64'd0);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        check("rst_st_ready",  64'(bus.st_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        // Table-driven single stores.
        bus.mem_ready = 1'b1;
        foreach (vecs[i]) begin
            bus.st_valid = 1'b1;
            bus.st_mode  = vecs[i].mode;
            bus.st_addr  = vecs[i].addr;
            bus.st_data  = vecs[i].data;
            check("vec_st_ready", 64'(bus.st_ready), 64'd1);
            push_beat(vecs[i].a0, vecs[i].d0, vecs[i].s0);
            if (vecs[i].nb == 2) push_beat(vecs[i].a1, vecs[i].d1, vecs[i].s1);
            tick();
            bus.st_valid = 1'b0;
            check("vec_latency_valid", 64'(bus.mem_valid), 64'd1);
            check("vec_latency_addr",  64'(bus.mem_addr),  64'(vecs[i].a0));
            wait_drain("vec_drain");
        end
        tick();
        check("empty_holds_last_addr", 64'(bus.mem_addr), 64'h0);
        check("empty_holds_last_dat",  64'(bus.mem_wdata), 64'h0000_1234);

        // Fill under stall: three aligned words accepted, fourth refused.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.st_valid = 1'b1;
            bus.st_mode  = 2'd2;
            bus.st_addr  = 32'h500 + 32'(16 * i);
            bus.st_data  = 32'hA0 + 32'(i);
            check("fill_st_ready", 64'(bus.st_ready), (i < 3) ? 64'd1 : 64'd0);
            if (bus.st_ready) push_model(2'd2, bus.st_addr, bus.st_data);
            tick();
            check("stall_valid", 64'(bus.mem_valid), 64'd1);
            check("stall_addr",  64'(bus.mem_addr),  64'h500);
            check("stall_wdata", 64'(bus.mem_wdata), 64'hA0);
        end
        bus.st_valid = 1'b0;
        check("full_count", 64'(buf_count), 64'd3);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("after_pop_count", 64'(buf_count),    64'd2);
        check("after_pop_ready", 64'(bus.st_ready), 64'd1);
        bus.st_valid = 1'b1; bus.st_mode = 2'd2; bus.st_addr = 32'h602; bus.st_data = 32'h1122_3344;
        push_model(2'd2, bus.st_addr, bus.st_data);
        tick();
        bus.st_valid = 1'b0;
        check("split_full_count", 64'(buf_count),    64'd4);
        check("split_full_ready", 64'(bus.st_ready), 64'd0);
        check("split_full_head",  64'(bus.mem_addr), 64'h510);
        bus.mem_ready = 1'b1;
        wait_drain("fill_drain");

        // Simultaneous push and pop at count 2.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.st_valid = 1'b1; bus.st_mode = 2'd2;
            bus.st_addr = 32'h800 + 32'(4 * i); bus.st_data = 32'hC0 + 32'(i);
            push_model(2'd2, bus.st_addr, bus.st_data);
            tick();
        end
        check("pp_pre_count", 64'(buf_count), 64'd2);
        bus.mem_ready = 1'b1;
        bus.st_addr = 32'h808; bus.st_data = 32'hC2;
        push_model(2'd2, bus.st_addr, bus.st_data);
        tick();
        bus.st_valid = 1'b0;
        check("pp_count", 64'(buf_count), 64'd2);
        wait_drain("pp_drain");

        // Reset with a split half still queued.
        bus.mem_ready = 1'b0;
        bus.st_valid = 1'b1; bus.st_mode = 2'd2; bus.st_addr = 32'h900; bus.st_data = 32'h1;
        tick();
        bus.st_addr = 32'h902; bus.st_data = 32'h2;
        tick();
        bus.st_valid = 1'b0;
        check("prerst_count", 64'(buf_count), 64'd3);
        rst_n = 1'b0;
        tick();
        check("midrst_count", 64'(buf_count),     64'd0);
        check("midrst_valid", 64'(bus.mem_valid), 64'd0);
        check("midrst_empty", 64'(buf_empty),     64'd1);
        check("midrst_addr",  64'(bus.mem_addr),  64'd0);
        rst_n = 1'b1;
        sb_q.delete();
        tick();
        bus.mem_ready = 1'b1;
        bus.st_valid = 1'b1; bus.st_mode = 2'd0; bus.st_addr = 32'hA01; bus.st_data = 32'h77;
        push_model(2'd0, bus.st_addr, bus.st_data);
        tick();
        bus.st_valid = 1'b0;
        wait_drain("postrst_drain");

        // Random traffic against the scoreboard.
        beats_exp = 0; beats_seen = 0; accepted = 0;
        for (int c = 0; c < 20000 && accepted < 500; c++) begin
            rmode = 2'($urandom_range(0, 3));
            raddr = $urandom;
            rdata = $urandom;
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.st_valid  = ($urandom_range(0, 2) != 0);
            bus.st_mode = rmode; bus.st_addr = raddr; bus.st_data = rdata;
            if (bus.st_valid && bus.st_ready) begin
                push_model(rmode, raddr, rdata);
                accepted++;
            end
            tick();
        end
        bus.st_valid = 1'b0;
        bus.mem_ready = 1'b1;
        check("rand_accepted", 64'(accepted), 64'd500);
        wait_drain("rand_drain");
        check("rand_beats", 64'(beats_seen), 64'(beats_exp));
        check("rand_count", 64'(buf_count),  64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
